// File: rtl/border_collision_detect_if.sv
// Pixel-stream bundle between the raster drawers and border_collision_detect.
// Handshake: no valid/ready. Every clk cycle carries exactly one pixel. startOfFrame marks the first pixel of a frame, and the consumer never stalls the stream. collision is a one-cycle pulse. collisionSide/hitX/hitY stay valid until the next pulse.
interface border_collision_detect_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [1:0]  bordersDrawReq;
  logic        ballDrawReq;
  logic        collision;
  logic [1:0]  collisionSide;
  logic [10:0] hitX;
  logic [10:0] hitY;

  modport master (
    output startOfFrame, pixelX, pixelY, bordersDrawReq, ballDrawReq,
    input  collision, collisionSide, hitX, hitY
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, bordersDrawReq, ballDrawReq,
    output collision, collisionSide, hitX, hitY
  );
endinterface

// File: rtl/border_collision_detect.sv
// Reports ball/border collisions once per frame, then ignores HOLDOFF_FRAMES whole frames.
// Optional macro BORDER_COLLISION_COORD_EN builds first-hit coordinate capture; otherwise hitX/hitY are 0.
module border_collision_detect #(
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  border_collision_detect_if.slave        bcd,
  output logic [1:0]                      state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_FRAMES);

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  side_acc_q, side_acc_d;
  logic        first_seen_q, first_seen_d;
  logic        collision_q, collision_d;
  logic [1:0]  side_q, side_d;
  logic        hit;

  assign hit = bcd.ballDrawReq && (bcd.bordersDrawReq != 2'b00);

`ifdef BORDER_COLLISION_COORD_EN
  logic [10:0] first_x_q, first_x_d;
  logic [10:0] first_y_q, first_y_d;
  logic [10:0] hit_x_q, hit_x_d;
  logic [10:0] hit_y_q, hit_y_d;
`else
  logic unused_coords;
  assign unused_coords = ^{bcd.pixelX, bcd.pixelY};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 4'd0;
      side_acc_q   <= 2'b00;
      first_seen_q <= 1'b0;
      collision_q  <= 1'b0;
      side_q       <= 2'b00;
`ifdef BORDER_COLLISION_COORD_EN
      first_x_q    <= 11'd0;
      first_y_q    <= 11'd0;
      hit_x_q      <= 11'd0;
      hit_y_q      <= 11'd0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      side_acc_q   <= side_acc_d;
      first_seen_q <= first_seen_d;
      collision_q  <= collision_d;
      side_q       <= side_d;
`ifdef BORDER_COLLISION_COORD_EN
      first_x_q    <= first_x_d;
      first_y_q    <= first_y_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    side_acc_d   = side_acc_q;
    first_seen_d = first_seen_q;
    collision_d  = 1'b0;
    side_d       = side_q;
`ifdef BORDER_COLLISION_COORD_EN
    first_x_d    = first_x_q;
    first_y_d    = first_y_q;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bcd.startOfFrame) begin
          state_d      = SCAN;
          side_acc_d   = 2'b00;
          first_seen_d = 1'b0;
        end
      end
      SCAN: begin
        // Decision uses the closing frame's accumulator, before any coincident hit.
        if (bcd.startOfFrame && (side_acc_q != 2'b00)) begin
          collision_d  = 1'b1;
          side_d       = side_acc_q;
`ifdef BORDER_COLLISION_COORD_EN
          hit_x_d      = first_x_q;
          hit_y_d      = first_y_q;
`endif
          side_acc_d   = 2'b00;
          first_seen_d = 1'b0;
          if (HOLDOFF_FRAMES != 0) begin
            state_d    = HOLDOFF;
            hold_cnt_d = HOLD_INIT;
          end
        end
      end
      HOLDOFF: begin
        if (bcd.startOfFrame) begin
          if (hold_cnt_q <= 4'd1) begin
            state_d    = SCAN;
            hold_cnt_d = 4'd0;
          end else begin
            hold_cnt_d = hold_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A hit counts only toward a frame that is being scanned; a coincident one opens the new frame.
    if (hit && (state_d == SCAN)) begin
      side_acc_d = side_acc_d | bcd.bordersDrawReq;
`ifdef BORDER_COLLISION_COORD_EN
      if (!first_seen_d) begin
        first_x_d = bcd.pixelX;
        first_y_d = bcd.pixelY;
      end
`endif
      first_seen_d = 1'b1;
    end
  end

  assign bcd.collision     = collision_q;
  assign bcd.collisionSide = side_q;
`ifdef BORDER_COLLISION_COORD_EN
  assign bcd.hitX          = hit_x_q;
  assign bcd.hitY          = hit_y_q;
`else
  assign bcd.hitX          = 11'd0;
  assign bcd.hitY          = 11'd0;
`endif
  assign state_o           = state_q;

endmodule

// File: tb/tb_border_collision_detect.sv
// Directed bench for border_collision_detect: frame-level reference model, per-cycle compare, literal pins.
module tb_border_collision_detect;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_o;

  border_collision_detect_if bus();

  border_collision_detect #(.HOLDOFF_FRAMES(HOLD)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bcd     (bus.slave),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Frame-level model: is a frame open, how many whole frames remain ignored, what the current frame saw.
  bit          running = 1'b0;
  int          ignore_left = 0;
  logic [1:0]  frame_side = 2'b00;
  bit          have_first = 1'b0;
  logic [10:0] first_x = '0, first_y = '0;
  logic        exp_col = 1'b0;
  logic [1:0]  exp_side = 2'b00;
  logic [10:0] exp_hx = '0, exp_hy = '0;
  logic [23:0] exp_q[$];

  function automatic logic [10:0] cx(input logic [10:0] v);
`ifdef BORDER_COLLISION_COORD_EN
    return v;
`else
    return 11'd0 & v;
`endif
  endfunction

  function automatic logic [1:0] exp_state();
    if (!running) return 2'd0;
    if (ignore_left > 0) return 2'd2;
    return 2'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit sof, input bit ball,
                              input logic [1:0] bd, input logic [10:0] x, input logic [10:0] y);
    exp_col = 1'b0;
    if (rst) begin
      running = 1'b0; ignore_left = 0; frame_side = 2'b00; have_first = 1'b0;
      exp_side = 2'b00; exp_hx = '0; exp_hy = '0;
      return;
    end
    if (sof) begin
      if (!running) begin
        running = 1'b1;
      end else if (ignore_left == 0) begin
        if (frame_side != 2'b00) begin
          exp_col  = 1'b1;
          exp_side = frame_side;
          exp_hx   = cx(first_x);
          exp_hy   = cx(first_y);
          exp_q.push_back({exp_side, exp_hx, exp_hy});
          ignore_left = HOLD;
        end
      end else begin
        ignore_left--;
      end
      if (exp_col || ignore_left == 0) begin
        frame_side = 2'b00;
        have_first = 1'b0;
      end
    end
    if (ball && bd != 2'b00 && running && ignore_left == 0) begin
      frame_side |= bd;
      if (!have_first) begin
        first_x = x; first_y = y; have_first = 1'b1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit sof, input bit ball,
                      input logic [1:0] bd, input logic [10:0] x, input logic [10:0] y);
    reset = rst;
    bus.startOfFrame = sof;
    bus.ballDrawReq = ball;
    bus.bordersDrawReq = bd;
    bus.pixelX = x;
    bus.pixelY = y;
    @(posedge clk);
    #1;
    model_update(rst, sof, ball, bd, x, y);
    cmp_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 11'(i), 11'd7);
  endtask

  task automatic sof();
    step(1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 11'd0);
  endtask

  task automatic hit(input logic [1:0] bd, input logic [10:0] x, input logic [10:0] y);
    step(1'b0, 1'b0, 1'b1, bd, x, y);
  endtask

  task automatic pin(input string tag, input logic c, input logic [1:0] s,
                     input logic [10:0] hx, input logic [10:0] hy, input logic [1:0] st);
    check({tag, "_collision"}, bus.collision, c);
    check({tag, "_side"}, bus.collisionSide, s);
    check({tag, "_hitX"}, bus.hitX, hx);
    check({tag, "_hitY"}, bus.hitY, hy);
    check({tag, "_state"}, state_o, st);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_collision", bus.collision, exp_col);
      check("cyc_side", bus.collisionSide, exp_side);
      check("cyc_hitX", bus.hitX, exp_hx);
      check("cyc_hitY", bus.hitY, exp_hy);
      check("cyc_state", state_o, exp_state());
      if (bus.collision === 1'b1) begin
        check("report_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          logic [23:0] r;
          r = exp_q.pop_front();
          check("report_record", {bus.collisionSide, bus.hitX, bus.hitY}, r);
        end
      end
    end
  end

  initial begin
    bus.startOfFrame = 1'b0; bus.ballDrawReq = 1'b0; bus.bordersDrawReq = 2'b00;
    bus.pixelX = '0; bus.pixelY = '0;

    step(1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 11'd0);
    step(1'b1, 1'b0, 1'b1, 2'b01, 11'd3, 11'd3);
    pin("reset", 1'b0, 2'b00, 11'd0, 11'd0, 2'd0);
    hit(2'b01, 11'd4, 11'd4);
    sof();
    pin("first_sof", 1'b0, 2'b00, 11'd0, 11'd0, 2'd1);

    idle(3); hit(2'b01, 11'd30, 11'd200); idle(2); sof();
    pin("single_hit", 1'b1, 2'b01, cx(11'd30), cx(11'd200), 2'd2);
    idle(1);
    pin("single_hold", 1'b0, 2'b01, cx(11'd30), cx(11'd200), 2'd2);

    hit(2'b10, 11'd100, 11'd10); idle(1); sof();
    pin("hold_f1", 1'b0, 2'b01, cx(11'd30), cx(11'd200), 2'd2);
    hit(2'b01, 11'd20, 11'd20); sof();
    pin("hold_f2", 1'b0, 2'b01, cx(11'd30), cx(11'd200), 2'd1);
    hit(2'b10, 11'd40, 11'd50); idle(2); sof();
    pin("after_hold", 1'b1, 2'b10, cx(11'd40), cx(11'd50), 2'd2);

    idle(2); sof(); idle(2); sof();
    hit(2'b11, 11'd30, 11'd30); idle(2); hit(2'b01, 11'd609, 11'd449); idle(1); sof();
    pin("corner", 1'b1, 2'b11, cx(11'd30), cx(11'd30), 2'd2);

    idle(2); sof(); idle(2); sof();
    idle(3);
    step(1'b0, 1'b1, 1'b1, 2'b01, 11'd5, 11'd6);
    pin("coinc_empty", 1'b0, 2'b11, cx(11'd30), cx(11'd30), 2'd1);
    idle(3); sof();
    pin("coinc_report", 1'b1, 2'b01, cx(11'd5), cx(11'd6), 2'd2);

    idle(2); sof();
    hit(2'b11, 11'd1, 11'd1);
    step(1'b0, 1'b1, 1'b1, 2'b10, 11'd7, 11'd8);
    pin("coinc_hold_exit", 1'b0, 2'b01, cx(11'd5), cx(11'd6), 2'd1);
    idle(2); sof();
    pin("coinc_hold_report", 1'b1, 2'b10, cx(11'd7), cx(11'd8), 2'd2);

    idle(2); sof(); idle(2); sof();
    hit(2'b01, 11'd11, 11'd12); idle(1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 11'd0);
    pin("mid_reset", 1'b0, 2'b00, 11'd0, 11'd0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 11'd0, 11'd0);
    pin("reset_vs_sof", 1'b0, 2'b00, 11'd0, 11'd0, 2'd0);
    sof(); idle(2); sof();
    pin("no_report_after_reset", 1'b0, 2'b00, 11'd0, 11'd0, 2'd1);
    idle(2);

    check("reports_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
